class_merge: RTL and testbench



---
 rtl/class_merge.sv | 139 +++++++++++++
 tb/tb_class_merge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/class_merge.sv
// Merges the class-0 and class-1 egress FIFOs into one registered stream with a valid strobe.
// The default build uses weighted round-robin; defining CLASS_MERGE_STRICT_PRIO_EN selects strict class-0 priority instead.
module class_merge #(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8,
    parameter int WEIGHT0   = 3,
    parameter int WEIGHT1   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] in0,
    input  logic [DATA_SIZE-1:0] in1,
    input  logic                 fifo_empty0,
    input  logic                 fifo_empty1,
    input  logic                 almost_full,
    output logic                 pop_0,
    output logic                 pop_1,
    output logic [DATA_SIZE-1:0] out,
    output logic                 valid_out,
    output logic                 Error
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 w_stall;
    logic                 r_inFlight;
    logic                 r_tag;
    logic [DATA_SIZE-1:0] w_capWord;

    assign w_stall = reset | almost_full;

`ifndef CLASS_MERGE_STRICT_PRIO_EN
    localparam logic [3:0] W0 = 4'(WEIGHT0);
    localparam logic [3:0] W1 = 4'(WEIGHT1);

    logic [3:0] r_cnt;
    logic [3:0] w_nextCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Stay on the granted class until its weight is used up, then hand over if the other class has data.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        if (!almost_full) begin
            if (pop_0) begin
                w_nextState = G0;
                w_nextCnt   = (r_state == G0 && r_cnt < W0) ? r_cnt + 4'd1 : 4'd1;
            end else if (pop_1) begin
                w_nextState = G1;
                w_nextCnt   = (r_state == G1 && r_cnt < W1) ? r_cnt + 4'd1 : 4'd1;
            end else begin
                w_nextState = IDLE;
                w_nextCnt   = 4'd0;
            end
        end
    end

    always_comb begin
        pop_0 = 1'b0;
        pop_1 = 1'b0;
        if (!w_stall) begin
            case (r_state)
                IDLE: begin
                    if (!fifo_empty0)      pop_0 = 1'b1;
                    else if (!fifo_empty1) pop_1 = 1'b1;
                end
                G0: begin
                    if (!fifo_empty0 && r_cnt < W0) pop_0 = 1'b1;
                    else if (!fifo_empty1)          pop_1 = 1'b1;
                    else if (!fifo_empty0)          pop_0 = 1'b1;
                end
                G1: begin
                    if (!fifo_empty1 && r_cnt < W1) pop_1 = 1'b1;
                    else if (!fifo_empty0)          pop_0 = 1'b1;
                    else if (!fifo_empty1)          pop_1 = 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // The state only records the last grant so it can be observed while debugging.
    always_comb begin
        w_nextState = r_state;
        if (!almost_full) begin
            if (pop_0)      w_nextState = G0;
            else if (pop_1) w_nextState = G1;
            else            w_nextState = IDLE;
        end
    end

    always_comb begin
        pop_0 = 1'b0;
        pop_1 = 1'b0;
        if (!w_stall) begin
            if (!fifo_empty0)      pop_0 = 1'b1;
            else if (!fifo_empty1) pop_1 = 1'b1;
        end
    end
`endif

    assign w_capWord = r_tag ? in1 : in0;

    // FIFO read data arrives one cycle after the pop, so the tag picks which input to capture then.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inFlight <= 1'b0;
            r_tag      <= 1'b0;
            out        <= '0;
            valid_out  <= 1'b0;
            Error      <= 1'b0;
        end else begin
            r_inFlight <= pop_0 | pop_1;
            r_tag      <= pop_1;
            valid_out  <= r_inFlight;
            if (r_inFlight) begin
                out <= {w_capWord[DATA_SIZE-1:MAIN_SIZE], w_capWord[MAIN_SIZE-1:0]};
                if (w_capWord[DATA_SIZE-1] != r_tag) Error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_class_merge.sv
// Self-checking bench for class_merge: directed table, hand-written corner sequences and randomized traffic
// compared against a queue-based model of the two FIFOs and the arbitration rules.
module tb_class_merge;

    localparam int DW      = 10;
    localparam int WEIGHT0 = 3;
    localparam int WEIGHT1 = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in0 = '0;
    logic [DW-1:0] in1 = '0;
    logic          fifo_empty0 = 1'b1;
    logic          fifo_empty1 = 1'b1;
    logic          almost_full = 1'b0;
    logic          pop_0;
    logic          pop_1;
    logic [DW-1:0] out;
    logic          valid_out;
    logic          Error;

    int vectors = 0;
    int miscompares = 0;

    // Bench FIFOs follow the DUT's pops; the model keeps its own copies and follows its own decisions.
    logic [DW-1:0] fq0[$];
    logic [DW-1:0] fq1[$];
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];

    int            mCls = -1;
    int            mRun = 0;
    int            mPick = -1;
    bit            mPipeVld = 1'b0;
    logic [DW-1:0] mPipeWord = '0;
    int            mPipeCls = 0;
    bit            mValid = 1'b0;
    logic [DW-1:0] mOut = '0;
    bit            mErr = 1'b0;

    typedef struct {
        bit            rst;
        bit            af;
        bit            expP0;
        bit            expP1;
        bit            expValid;
        logic [DW-1:0] expOut;
    } vec_t;

    class_merge #(
        .DATA_SIZE(DW),
        .MAIN_SIZE(8),
        .WEIGHT0  (WEIGHT0),
        .WEIGHT1  (WEIGHT1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in0        (in0),
        .in1        (in1),
        .fifo_empty0(fifo_empty0),
        .fifo_empty1(fifo_empty1),
        .almost_full(almost_full),
        .pop_0      (pop_0),
        .pop_1      (pop_1),
        .out        (out),
        .valid_out  (valid_out),
        .Error      (Error)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pushWord(input int cls, input logic [DW-1:0] w);
        if (cls == 0) begin
            fq0.push_back(w);
            mq0.push_back(w);
        end else begin
            fq1.push_back(w);
            mq1.push_back(w);
        end
    endtask

    function automatic int weightOf(input int cls);
        return (cls == 0) ? WEIGHT0 : WEIGHT1;
    endfunction

    // Which class the rules say to pop this cycle (-1 = none).
    task automatic modelDecide(output int cls);
        bit avail[2];
        avail[0] = (mq0.size() > 0);
        avail[1] = (mq1.size() > 0);
        cls = -1;
        if (!(reset || almost_full)) begin
`ifdef CLASS_MERGE_STRICT_PRIO_EN
            if (avail[0])      cls = 0;
            else if (avail[1]) cls = 1;
`else
            if (mCls < 0) begin
                if (avail[0])      cls = 0;
                else if (avail[1]) cls = 1;
            end else begin
                int x = mCls;
                int y = 1 - mCls;
                if (avail[x] && mRun < weightOf(x)) cls = x;
                else if (avail[y])                  cls = y;
                else if (avail[x])                  cls = x;
            end
`endif
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit af, output bit p0, output bit p1, output bit vDuring);
        reset       = rst;
        almost_full = af;
        fifo_empty0 = (fq0.size() == 0);
        fifo_empty1 = (fq1.size() == 0);
        #1;
        modelDecide(mPick);
        p0      = pop_0;
        p1      = pop_1;
        vDuring = valid_out;
        checkVal("pop_0", DW'(pop_0), DW'(mPick == 0));
        checkVal("pop_1", DW'(pop_1), DW'(mPick == 1));
        @(posedge clk);
        #1;
        if (p0 && fq0.size() > 0) in0 = fq0.pop_front();
        if (p1 && fq1.size() > 0) in1 = fq1.pop_front();
        if (rst) begin
            mCls     = -1;
            mRun     = 0;
            mPipeVld = 1'b0;
            mValid   = 1'b0;
            mOut     = '0;
            mErr     = 1'b0;
        end else begin
            mValid = mPipeVld;
            if (mPipeVld) begin
                mOut = mPipeWord;
                if (mPipeWord[DW-1] != (mPipeCls == 1)) mErr = 1'b1;
            end
            mPipeVld = (mPick >= 0);
            if (mPick == 0) mPipeWord = mq0.pop_front();
            if (mPick == 1) mPipeWord = mq1.pop_front();
            if (mPick >= 0) mPipeCls = mPick;
            if (!af) begin
                if (mPick >= 0) begin
                    mRun = (mPick == mCls && mRun < weightOf(mPick)) ? mRun + 1 : 1;
                    mCls = mPick;
                end else begin
                    mCls = -1;
                    mRun = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("valid_out", DW'(valid_out), DW'(mValid));
        checkVal("out", out, mOut);
        checkVal("Error", DW'(Error), DW'(mErr));
    endtask

    task automatic cycle(input bit rst, input bit af, output bit p0, output bit p1, output bit vDuring);
        applyStimulus(rst, af, p0, p1, vDuring);
        checkOutput();
    endtask

    initial begin : main
        vec_t          tbl[8];
        int            expOrder[9];
        bit            p0;
        bit            p1;
        bit            vd;
        int            got;
        int            tailCount;
        logic [DW-1:0] w;
        int            c;

        // Single class-0 burst: weight boundary with the other FIFO empty, then drain to IDLE.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h001};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h002};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h003};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h004};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h004};

`ifdef CLASS_MERGE_STRICT_PRIO_EN
        expOrder = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
        expOrder = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
`endif

        $display("[TB] table: single class-0 burst");
        for (int i = 1; i <= 4; i++) pushWord(0, DW'(i));
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].rst, tbl[i].af, p0, p1, vd);
            checkVal($sformatf("tbl%0d_pop_0", i), DW'(p0), DW'(tbl[i].expP0));
            checkVal($sformatf("tbl%0d_pop_1", i), DW'(p1), DW'(tbl[i].expP1));
            checkVal($sformatf("tbl%0d_valid", i), DW'(valid_out), DW'(tbl[i].expValid));
            checkVal($sformatf("tbl%0d_out", i), out, tbl[i].expOut);
            checkVal($sformatf("tbl%0d_Error", i), DW'(Error), DW'(0));
        end

        $display("[TB] interleave: both classes loaded");
        cycle(1'b1, 1'b0, p0, p1, vd);
        for (int i = 0; i < 8; i++) begin
            pushWord(0, {2'b00, 8'(i)});
            pushWord(1, {2'b10, 8'(i)});
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, p0, p1, vd);
            got = p1 ? 1 : (p0 ? 0 : 2);
            checkVal($sformatf("busy%0d", i), DW'(p0 | p1), DW'(1));
            if (i < 9) checkVal($sformatf("order%0d", i), DW'(got), DW'(expOrder[i]));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, p0, p1, vd);

        $display("[TB] back-pressure");
        cycle(1'b1, 1'b0, p0, p1, vd);
        for (int i = 0; i < 6; i++) begin
            pushWord(0, {2'b00, 8'(8'h40 + i)});
            pushWord(1, {2'b10, 8'(8'h50 + i)});
        end
        cycle(1'b0, 1'b0, p0, p1, vd);
        cycle(1'b0, 1'b0, p0, p1, vd);
        tailCount = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, p0, p1, vd);
            checkVal($sformatf("bp_nopop%0d", i), DW'(p0 | p1), DW'(0));
            if (vd) tailCount++;
        end
        checkVal("bp_tail", DW'(tailCount), DW'(2));
        cycle(1'b0, 1'b0, p0, p1, vd);
        checkVal("bp_resume0", DW'(p0), DW'(1));
        cycle(1'b0, 1'b0, p0, p1, vd);
`ifdef CLASS_MERGE_STRICT_PRIO_EN
        checkVal("bp_resume1", DW'(p0), DW'(1));
`else
        checkVal("bp_resume1", DW'(p1), DW'(1));
`endif
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, p0, p1, vd);

        $display("[TB] class mismatch");
        cycle(1'b1, 1'b0, p0, p1, vd);
        pushWord(0, 10'h2AA);
        cycle(1'b0, 1'b0, p0, p1, vd);
        checkVal("err_before", DW'(Error), DW'(0));
        cycle(1'b0, 1'b0, p0, p1, vd);
        checkVal("err_set", DW'(Error), DW'(1));
        checkVal("err_word", out, 10'h2AA);
        cycle(1'b0, 1'b0, p0, p1, vd);
        cycle(1'b0, 1'b0, p0, p1, vd);
        checkVal("err_sticky", DW'(Error), DW'(1));
        cycle(1'b1, 1'b0, p0, p1, vd);
        checkVal("err_cleared", DW'(Error), DW'(0));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (fq0.size() < 8 && ($urandom % 2) == 0) begin
                w = DW'($urandom);
                w[DW-1] = (($urandom % 50) == 0);
                pushWord(0, w);
            end
            if (fq1.size() < 8 && ($urandom % 3) == 0) begin
                w = DW'($urandom);
                w[DW-1] = !(($urandom % 50) == 0);
                pushWord(1, w);
            end
            c = $urandom % 100;
            cycle(c == 0, ($urandom % 4) == 0, p0, p1, vd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
